// File: rtl/execute_muldiv.sv
// Multi-cycle RV32M execute unit: iterative radix-2 multiply and restoring divide on operand
// magnitudes, one result bit per cycle, with sign correction and divide special cases.
module execute_muldiv #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [XLEN-1:0]  in_opd1,
    input  logic [XLEN-1:0]  in_opd2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_result,
    output logic [TAG_W-1:0] out_tag
);

    localparam int CNT_W = $clog2(XLEN);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  ONE      = {{(XLEN-1){1'b0}}, 1'b1};
    localparam logic [XLEN-1:0]  MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0]  ALL_ONES = {XLEN{1'b1}};

    function automatic logic [XLEN-1:0] cond_neg(input logic [XLEN-1:0] v, input logic neg);
        if (neg) begin
            cond_neg = ~v + ONE;
        end else begin
            cond_neg = v;
        end
    endfunction

    function automatic logic [2*XLEN-1:0] cond_neg_wide(input logic [2*XLEN-1:0] v, input logic neg);
        if (neg) begin
            cond_neg_wide = ~v + {{(2*XLEN-1){1'b0}}, 1'b1};
        end else begin
            cond_neg_wide = v;
        end
    endfunction

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             neg_q, neg_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;
    logic [XLEN-1:0]  res_q, res_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             sgn1_s, sgn2_s, neg_in_s, div_zero_s, div_ovf_s;
    logic [XLEN-1:0]  special_res_s, hi_n_s, lo_n_s, final_s;
    logic [XLEN:0]    mul_sum_s, div_shift_s, div_trial_s;
    logic [2*XLEN-1:0] prod_s;

    // Decode operand signedness, result sign and the divide special cases of the incoming uop
    always_comb begin
        sgn1_s = 1'b0;
        sgn2_s = 1'b0;
        case (in_op)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                sgn1_s = 1'b1;
                sgn2_s = 1'b1;
            end
            3'd2: begin
                sgn1_s = 1'b1;
                sgn2_s = 1'b0;
            end
            default: begin
                sgn1_s = 1'b0;
                sgn2_s = 1'b0;
            end
        endcase
        // Remainder sign follows the dividend only
        if (in_op == 3'd6) begin
            neg_in_s = in_opd1[XLEN-1];
        end else begin
            neg_in_s = (sgn1_s & in_opd1[XLEN-1]) ^ (sgn2_s & in_opd2[XLEN-1]);
        end
        div_zero_s = in_op[2] && (in_opd2 == {XLEN{1'b0}});
        div_ovf_s  = in_op[2] && !in_op[0] && (in_opd1 == MIN_NEG) && (in_opd2 == ALL_ONES);
        if (div_zero_s) begin
            special_res_s = in_op[1] ? in_opd1 : ALL_ONES;
        end else if (div_ovf_s) begin
            special_res_s = in_op[1] ? {XLEN{1'b0}} : in_opd1;
        end else begin
            special_res_s = {XLEN{1'b0}};
        end
    end

    // One radix-2 iteration plus the sign-corrected result of the final iteration
    always_comb begin
        mul_sum_s   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_q, lo_q[XLEN-1]};
        div_trial_s = div_shift_s - {1'b0, b_q};
        if (op_q[2]) begin
            if (div_trial_s[XLEN]) begin
                hi_n_s = div_shift_s[XLEN-1:0];
                lo_n_s = {lo_q[XLEN-2:0], 1'b0};
            end else begin
                hi_n_s = div_trial_s[XLEN-1:0];
                lo_n_s = {lo_q[XLEN-2:0], 1'b1};
            end
        end else begin
            hi_n_s = mul_sum_s[XLEN:1];
            lo_n_s = {mul_sum_s[0], lo_q[XLEN-1:1]};
        end
        prod_s = cond_neg_wide({hi_n_s, lo_n_s}, neg_q);
        case (op_q)
            3'd0:             final_s = prod_s[XLEN-1:0];
            3'd1, 3'd2, 3'd3: final_s = prod_s[2*XLEN-1:XLEN];
            3'd4, 3'd5:       final_s = cond_neg(lo_n_s, neg_q);
            default:          final_s = cond_neg(hi_n_s, neg_q);
        endcase
    end

    // Control FSM and datapath next-state; flush overrides everything
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        neg_d   = neg_q;
        b_d     = b_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        res_d   = res_q;
        tag_d   = tag_q;
        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        tag_d = in_tag;
                        op_d  = in_op;
                        neg_d = neg_in_s;
                        cnt_d = {CNT_W{1'b0}};
                        hi_d  = {XLEN{1'b0}};
                        if (div_zero_s || div_ovf_s) begin
                            state_d = S_DONE;
                            res_d   = special_res_s;
                        end else if (in_op[2]) begin
                            state_d = S_BUSY;
                            lo_d    = cond_neg(in_opd1, sgn1_s & in_opd1[XLEN-1]);
                            b_d     = cond_neg(in_opd2, sgn2_s & in_opd2[XLEN-1]);
                        end else begin
                            state_d = S_BUSY;
                            lo_d    = cond_neg(in_opd2, sgn2_s & in_opd2[XLEN-1]);
                            b_d     = cond_neg(in_opd1, sgn1_s & in_opd1[XLEN-1]);
                        end
                    end else begin
                        state_d = S_IDLE;
                    end
                end
                S_BUSY: begin
                    hi_d = hi_n_s;
                    lo_d = lo_n_s;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_DONE;
                        cnt_d   = {CNT_W{1'b0}};
                        res_d   = final_s;
                    end else begin
                        cnt_d = cnt_q + CNT_ONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= {CNT_W{1'b0}};
            op_q    <= 3'd0;
            neg_q   <= 1'b0;
            b_q     <= {XLEN{1'b0}};
            hi_q    <= {XLEN{1'b0}};
            lo_q    <= {XLEN{1'b0}};
            res_q   <= {XLEN{1'b0}};
            tag_q   <= {TAG_W{1'b0}};
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            neg_q   <= neg_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            res_q   <= res_d;
            tag_q   <= tag_d;
        end
    end

    assign in_ready   = (state_q == S_IDLE);
    assign out_valid  = (state_q == S_DONE);
    assign out_result = res_q;
    assign out_tag    = tag_q;

endmodule
